// File: rtl/uart_tx_pkg.sv
// Shared register map, STATUS bit layout and transmitter FSM states for uart_tx_mmio.
package uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO holding bytes queued for transmission.
// Latency: push visible at dout one cycle later; dout is the combinational head.
// Backpressure: push on full is dropped unless a pop happens in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot the push needs, so full only blocks a lone push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO on the external data bus.
// Latency: register reads combinational; a push starts a frame two edges later when idle.
// Backpressure: none on the bus; pushes to a full FIFO are dropped and flag overflow.
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        cs,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          sel;
    logic          wr;
    logic [1:0]    reg_idx;
    logic [15:0]   div;
    logic [15:0]   reload;
    logic          enable;
    logic          overflow;
    logic          busy;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_done;
    logic          unused_wdata;

    assign sel          = !cs && (addr[31:2] == BASE_ADDR[31:2]);
    assign reg_idx      = addr[1:0];
    assign wr           = sel && we;
    assign fifo_push    = wr && (reg_idx == REG_TXDATA);
    assign unused_wdata = ^wdata[31:16];

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            div      <= DEFAULT_DIV;
            enable   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr && reg_idx == REG_BAUDDIV) begin
                div <= wdata[15:0];
            end
            if (wr && reg_idx == REG_CTRL) begin
                enable <= wdata[0];
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (wr && reg_idx == REG_STATUS && wdata[ST_OVERFLOW]) begin
                overflow <= 1'b0;
            end
        end
    end

    // A divisor of 0 behaves as 1; sampled only at bit boundaries so mid-frame writes wait.
    assign reload   = (div == 16'd0) ? 16'd0 : div - 16'd1;
    assign bit_done = (baud_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_done) state_nxt = DATA;
            end
            DATA: begin
                if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    if (enable && !fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            if (fifo_pop || (state != IDLE && bit_done)) begin
                baud_cnt <= reload;
            end else if (state != IDLE) begin
                baud_cnt <= baud_cnt - 16'd1;
            end
            if (fifo_pop) begin
                shift <= fifo_dout;
            end else if (state == DATA && bit_done) begin
                shift <= {1'b0, shift[7:1]};
            end
            if (state == START && bit_done) begin
                bit_idx <= 3'd0;
            end else if (state == DATA && bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        busy = (state != IDLE);
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift[0];
            default: tx = 1'b1;
        endcase
    end

    assign irq = enable && fifo_empty && !busy;

    always_comb begin
        rdata = '0;
        if (sel && !we) begin
            case (reg_idx)
                REG_STATUS: begin
                    rdata[ST_FULL]     = fifo_full;
                    rdata[ST_EMPTY]    = fifo_empty;
                    rdata[ST_BUSY]     = busy;
                    rdata[ST_OVERFLOW] = overflow;
                    rdata[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
                end
                REG_BAUDDIV: rdata[15:0] = div;
                REG_CTRL:    rdata[0]    = enable;
                default:     rdata       = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register map, frame timing, overflow, decode and reset.
module tb_uart_tx_mmio;

    localparam logic [31:0] A_TXDATA  = 32'h0000_0400;
    localparam logic [31:0] A_STATUS  = 32'h0000_0401;
    localparam logic [31:0] A_BAUDDIV = 32'h0000_0402;
    localparam logic [31:0] A_CTRL    = 32'h0000_0403;
    localparam logic [31:0] A_IDLE    = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        cs;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int errors = 0;
    int checks = 0;

    uart_tx_mmio dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .cs    (cs),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called between edges; the write lands on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        cs    = 1'b0;
        @(negedge clk);
        #1;
        we    = 1'b0;
        addr  = A_IDLE;
        wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        cs   = 1'b0;
        #1;
        d    = rdata;
        addr = A_IDLE;
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b0; addr = A_IDLE; wdata = '0; we = 1'b0; cs = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL reset_status got=%h exp=00000002", d); end
        bus_read(A_BAUDDIV, d);
        checks++;
        if (d !== 32'd434) begin errors++; $display("FAIL reset_bauddiv got=%0d exp=434", d); end
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", d); end
        rst = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_single_frame;
        logic [40:0] obs;
        logic [40:0] exp;
        logic [7:0]  data;
        logic        irq_mid;
        logic [31:0] d;
        data = 8'hA5;
        bus_write(A_BAUDDIV, 32'd4);
        bus_write(A_CTRL, 32'd1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL idle_irq got=%b exp=1", irq); end
        bus_write(A_TXDATA, {24'd0, data});
        irq_mid = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            obs[i] = tx;
            if (i == 0)       exp[i] = 1'b1;
            else if (i <= 4)  exp[i] = 1'b0;
            else if (i <= 36) exp[i] = data[(i - 5) / 4];
            else              exp[i] = 1'b1;
            if (i > 0 && irq) irq_mid = 1'b1;
        end
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL frame_a5 got=%b exp=%b", obs, exp); end
        checks++;
        if (irq_mid !== 1'b0) begin errors++; $display("FAIL frame_irq_mid got=%b exp=0", irq_mid); end
        @(negedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL frame_irq_after got=%b exp=1", irq); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL frame_status_after got=%h exp=00000002", d); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        bus_write(A_CTRL, 32'd0);
        for (int i = 0; i < 9; i++) begin
            bus_write(A_TXDATA, 32'h10 + i);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h89) begin errors++; $display("FAIL ovf_status got=%h exp=00000089", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq got=%b exp=0", irq); end
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h81) begin errors++; $display("FAIL ovf_clear got=%h exp=00000081", d); end
        // Push into a full FIFO on the same edge the launch pops it.
        bus_write(A_BAUDDIV, 32'd1);
        bus_write(A_CTRL, 32'd1);
        bus_write(A_TXDATA, 32'h5A);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h85) begin errors++; $display("FAIL full_push_pop got=%h exp=00000085", d); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL ovf_reset_status got=%h exp=00000002", d); end
    endtask

    task automatic test_back_to_back;
        logic [40:0] obs;
        logic [40:0] exp;
        bus_write(A_BAUDDIV, 32'd2);
        bus_write(A_TXDATA, 32'h00);
        bus_write(A_TXDATA, 32'hFF);
        bus_write(A_CTRL, 32'd1);
        for (int i = 0; i <= 40; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            obs[i] = tx;
            exp[i] = (i == 0) || (i >= 19 && i <= 20) || (i >= 23);
        end
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL b2b_timeline got=%b exp=%b", obs, exp); end
        @(negedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL b2b_irq_after got=%b exp=1", irq); end
    endtask

    task automatic test_decode;
        logic [31:0] d;
        logic        tx_low;
        addr = A_TXDATA; wdata = 32'h33; we = 1'b1; cs = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL dec_cs_rdata got=%h exp=0", rdata); end
        @(negedge clk);
        #1;
        we = 1'b0; cs = 1'b0; addr = A_IDLE;
        bus_write(32'h0000_0404, 32'h44);
        addr = A_STATUS; cs = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL dec_cs_read got=%h exp=0", rdata); end
        cs = 1'b0; addr = 32'h0000_0405;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL dec_window_read got=%h exp=0", rdata); end
        addr = A_STATUS; we = 1'b1; wdata = '0;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL dec_we_read got=%h exp=0", rdata); end
        we = 1'b0; addr = A_IDLE;
        tx_low = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (tx !== 1'b1) tx_low = 1'b1;
        end
        checks++;
        if (tx_low !== 1'b0) begin errors++; $display("FAIL dec_tx_idle got=%b exp=0", tx_low); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL dec_status got=%h exp=00000002", d); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        logic        tx_low;
        bus_write(A_BAUDDIV, 32'd4);
        bus_write(A_TXDATA, 32'hA5);
        bus_write(A_TXDATA, 32'h3C);
        repeat (17) @(negedge clk);
        #1;
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 got=%b exp=0", tx); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h14) begin errors++; $display("FAIL mid_status got=%h exp=00000014", d); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL rstmid_status got=%h exp=00000002", d); end
        bus_read(A_BAUDDIV, d);
        checks++;
        if (d !== 32'd434) begin errors++; $display("FAIL rstmid_bauddiv got=%0d exp=434", d); end
        rst = 1'b1;
        tx_low = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (tx !== 1'b1) tx_low = 1'b1;
        end
        checks++;
        if (tx_low !== 1'b0) begin errors++; $display("FAIL rstmid_no_frame got=%b exp=0", tx_low); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_decode();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
